// File: rtl/lcd_controller.sv
// Byte-level front end for the 4-bit HD44780 path: power-up wait, nibble-mode init, then byte writes.
// Optional feature LCD_CURSOR_TRACK_EN adds 16x2 cursor tracking with automatic line wrap.
module lcd_controller #(
    parameter int POWERUP_CYCLES   = 750000,
    parameter int LONG_INIT_DELAY  = 205000,
    parameter int SHORT_INIT_DELAY = 5000,
    parameter int CMD_DELAY        = 2000,
    parameter int LONG_CMD_DELAY   = 82000,
    parameter int NIBBLE_DELAY     = 50
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        wr_valid,
    input  logic        wr_rs,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    output logic        init_done,
    output logic        sendCommand,
    output logic [4:0]  command,
    output logic [20:0] commandDelay,
    input  logic        commandDone
);

    // state      | meaning
    // POWERUP    | waiting POWERUP_CYCLES after reset
    // INIT_ISSUE | pulse one raw init nibble (0x3,0x3,0x3,0x2)
    // INIT_WAIT  | wait commandDone for init nibble
    // GAP        | one idle cycle after commandDone, then pick next step
    // IDLE       | init done, accepting bytes
    // HI_ISSUE   | pulse high nibble of current byte
    // HI_WAIT    | wait commandDone for high nibble
    // LO_ISSUE   | pulse low nibble of current byte
    // LO_WAIT    | wait commandDone for low nibble
    // FIX_ISSUE  | pulse a nibble of the line-wrap DDRAM address (tracking build)
    // FIX_WAIT   | wait commandDone for wrap nibble (tracking build)
    typedef enum logic [3:0] {
        POWERUP, INIT_ISSUE, INIT_WAIT, GAP, IDLE,
        HI_ISSUE, HI_WAIT, LO_ISSUE, LO_WAIT, FIX_ISSUE, FIX_WAIT
    } state_t;

    localparam int DELAY_MAX = (1 << 21) - 1;
    localparam int PW        = $clog2(POWERUP_CYCLES + 1);

    if (LONG_INIT_DELAY > DELAY_MAX || SHORT_INIT_DELAY > DELAY_MAX || CMD_DELAY > DELAY_MAX ||
        LONG_CMD_DELAY > DELAY_MAX || NIBBLE_DELAY > DELAY_MAX || POWERUP_CYCLES <= LONG_INIT_DELAY + 16)
    begin : g_bad_param
        $error("lcd_controller: illegal delay parameter");
    end

    localparam logic [20:0]   D_LONG_INIT  = 21'(LONG_INIT_DELAY);
    localparam logic [20:0]   D_SHORT_INIT = 21'(SHORT_INIT_DELAY);
    localparam logic [20:0]   D_CMD        = 21'(CMD_DELAY);
    localparam logic [20:0]   D_LONG_CMD   = 21'(LONG_CMD_DELAY);
    localparam logic [20:0]   D_NIBBLE     = 21'(NIBBLE_DELAY);
    localparam logic [PW-1:0] PWR_LAST     = PW'(POWERUP_CYCLES - 1);

    function automatic logic [3:0] init_nib(input logic [2:0] i);
        return (i == 3'd3) ? 4'h2 : 4'h3;
    endfunction

    function automatic logic [20:0] init_dly(input logic [2:0] i);
        case (i)
            3'd0:    return D_LONG_INIT;
            3'd1:    return D_SHORT_INIT;
            default: return D_CMD;
        endcase
    endfunction

    function automatic logic [7:0] init_byte(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h28;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // clear (0x01) and home (0x02/0x03) need the long settle time
    function automatic logic [20:0] lo_delay(input logic rs, input logic [7:0] d);
        return (!rs && d[7:2] == 6'd0 && d != 8'd0) ? D_LONG_CMD : D_CMD;
    endfunction

    state_t          state_q, state_d, prev_q, prev_d;
    logic [PW-1:0]   pwr_cnt_q, pwr_cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic            rs_q, rs_d;
    logic [7:0]      data_q, data_d;
    logic [4:0]      cmd_d;
    logic [20:0]     dly_d;
    logic            init_done_d;
`ifdef LCD_CURSOR_TRACK_EN
    logic            line_q, line_d, wrap_q, wrap_d, fix_lo_q, fix_lo_d;
    logic [3:0]      col_q, col_d;
    logic [7:0]      fix_byte;
`endif

    assign wr_ready    = (state_q == IDLE) && init_done;
    assign sendCommand = (state_q == INIT_ISSUE) || (state_q == HI_ISSUE) ||
                         (state_q == LO_ISSUE)   || (state_q == FIX_ISSUE);

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        pwr_cnt_d   = pwr_cnt_q;
        idx_d       = idx_q;
        rs_d        = rs_q;
        data_d      = data_q;
        cmd_d       = command;
        dly_d       = commandDelay;
        init_done_d = init_done;
`ifdef LCD_CURSOR_TRACK_EN
        line_d      = line_q;
        col_d       = col_q;
        wrap_d      = wrap_q;
        fix_lo_d    = fix_lo_q;
        fix_byte    = line_q ? 8'h80 : 8'hC0;
`endif
        case (state_q)
            POWERUP: begin
                if (pwr_cnt_q == PWR_LAST) begin
                    state_d = INIT_ISSUE;
                    idx_d   = 3'd0;
                    cmd_d   = {1'b0, init_nib(3'd0)};
                    dly_d   = init_dly(3'd0);
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 1'b1;
                end
            end
            INIT_ISSUE: state_d = INIT_WAIT;
            HI_ISSUE:   state_d = HI_WAIT;
            LO_ISSUE:   state_d = LO_WAIT;
            FIX_ISSUE:  state_d = FIX_WAIT;
            INIT_WAIT, HI_WAIT, LO_WAIT, FIX_WAIT: begin
                if (commandDone) begin
                    prev_d  = state_q;
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
                case (prev_q)
                    INIT_WAIT: begin
                        idx_d = idx_q + 3'd1;
                        if (idx_q == 3'd3) begin
                            rs_d    = 1'b0;
                            data_d  = init_byte(2'd0);
                            cmd_d   = {1'b0, data_d[7:4]};
                            dly_d   = D_NIBBLE;
                            state_d = HI_ISSUE;
                        end else begin
                            cmd_d   = {1'b0, init_nib(idx_d)};
                            dly_d   = init_dly(idx_d);
                            state_d = INIT_ISSUE;
                        end
                    end
                    HI_WAIT: begin
                        cmd_d   = {rs_q, data_q[3:0]};
                        dly_d   = lo_delay(rs_q, data_q);
                        state_d = LO_ISSUE;
                    end
                    LO_WAIT: begin
                        if (!init_done) begin
                            if (idx_q == 3'd7) begin
                                init_done_d = 1'b1;
                            end else begin
                                idx_d   = idx_q + 3'd1;
                                rs_d    = 1'b0;
                                data_d  = init_byte(idx_d[1:0]);
                                cmd_d   = {1'b0, data_d[7:4]};
                                dly_d   = D_NIBBLE;
                                state_d = HI_ISSUE;
                            end
                        end
`ifdef LCD_CURSOR_TRACK_EN
                        else if (wrap_q) begin
                            wrap_d   = 1'b0;
                            fix_lo_d = 1'b0;
                            line_d   = ~line_q;
                            rs_d     = 1'b0;
                            data_d   = fix_byte;
                            cmd_d    = {1'b0, fix_byte[7:4]};
                            dly_d    = D_NIBBLE;
                            state_d  = FIX_ISSUE;
                        end
`endif
                    end
`ifdef LCD_CURSOR_TRACK_EN
                    FIX_WAIT: begin
                        if (!fix_lo_q) begin
                            fix_lo_d = 1'b1;
                            cmd_d    = {1'b0, data_q[3:0]};
                            dly_d    = D_CMD;
                            state_d  = FIX_ISSUE;
                        end
                    end
`endif
                    default: state_d = IDLE;
                endcase
            end
            IDLE: begin
                if (wr_valid && init_done) begin
                    rs_d    = wr_rs;
                    data_d  = wr_data;
                    cmd_d   = {wr_rs, wr_data[7:4]};
                    dly_d   = D_NIBBLE;
                    state_d = HI_ISSUE;
`ifdef LCD_CURSOR_TRACK_EN
                    wrap_d  = 1'b0;
                    if (wr_rs) begin
                        col_d  = col_q + 4'd1;
                        wrap_d = (col_q == 4'hF);
                    end else if (wr_data[7]) begin
                        line_d = wr_data[6];
                        col_d  = wr_data[3:0];
                    end else if (wr_data[7:2] == 6'd0 && wr_data != 8'd0) begin
                        line_d = 1'b0;
                        col_d  = 4'd0;
                    end
`endif
                end
            end
            default: state_d = POWERUP;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= POWERUP;
            prev_q       <= POWERUP;
            pwr_cnt_q    <= '0;
            idx_q        <= '0;
            rs_q         <= 1'b0;
            data_q       <= '0;
            command      <= '0;
            commandDelay <= '0;
            init_done    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            pwr_cnt_q    <= pwr_cnt_d;
            idx_q        <= idx_d;
            rs_q         <= rs_d;
            data_q       <= data_d;
            command      <= cmd_d;
            commandDelay <= dly_d;
            init_done    <= init_done_d;
        end
    end

`ifdef LCD_CURSOR_TRACK_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            line_q   <= 1'b0;
            col_q    <= '0;
            wrap_q   <= 1'b0;
            fix_lo_q <= 1'b0;
        end else begin
            line_q   <= line_d;
            col_q    <= col_d;
            wrap_q   <= wrap_d;
            fix_lo_q <= fix_lo_d;
        end
    end
`endif

endmodule
